mul_div_unit: RTL

- Sequential signed multiply/divide engine for the datapath ALU.
- Takes the Y-register operand and the bus operand when the control step issues opcode 10000 (MUL) or 10001 (DIV).
- Produces a 64-bit result for the Z register: high word is driven onto the bus by ZHighOut for HIin, low word by ZLowOut for LOin.
- Replaces the single-cycle multiply path so the control unit can stall a T-step on `busy` until `done`.

---
 rtl/mul_div_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Sequential signed multiply/divide engine for the datapath ALU.
//               MUL uses radix-4 Booth (16 steps); DIV uses non-restoring
//               division on operand magnitudes (32 steps) plus a sign-fix
//               cycle. The 64-bit result feeds the Z register (hi/lo words).
// Ports       : clock        - system clock, rising edge
//               clear        - asynchronous active-high reset
//               start/opcode - request and operation select (sampled in IDLE)
//               a, b         - operands (Y register, bus), two's complement
//               busy, done   - handshake (done is a one-cycle pulse)
//               result_hi/lo - MUL product / DIV remainder and quotient
//               div_by_zero  - raised with done when DIV had b == 0
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter logic [4:0] MUL_OP = 5'b10000,
    parameter logic [4:0] DIV_OP = 5'b10001
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo,
    output logic        div_by_zero
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [33:0] hi_q, hi_d;      // Booth accumulator A, or DIV partial remainder
    logic [31:0] lo_q, lo_d;      // Booth multiplier Q, or DIV dividend/quotient
    logic        qm1_q, qm1_d;    // Booth q-1 bit
    logic [31:0] m_q, m_d;        // multiplicand, or divisor magnitude
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        dbz_q, dbz_d;    // pending div-by-zero flag, published at DONE
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_hi_q, result_hi_d;
    logic [31:0] result_lo_q, result_lo_d;
    logic        div_by_zero_q, div_by_zero_d;

    logic [33:0] booth_pp;
    logic [33:0] booth_sum;
    logic [32:0] div_ext;
    logic [32:0] div_shift;
    logic [32:0] div_sum;
    logic [32:0] rem_fix;

    always_comb begin
        // Booth recoding of {Q[1:0], q-1}: partial product in {0, +-M, +-2M}
        case ({lo_q[1:0], qm1_q})
            3'b001, 3'b010: booth_pp = {{2{m_q[31]}}, m_q};
            3'b011:         booth_pp = {m_q[31], m_q, 1'b0};
            3'b100:         booth_pp = -{m_q[31], m_q, 1'b0};
            3'b101, 3'b110: booth_pp = -{{2{m_q[31]}}, m_q};
            default:        booth_pp = 34'd0;
        endcase
        booth_sum = hi_q + booth_pp;

        // Non-restoring step: add divisor when remainder negative, else subtract.
        // Arithmetic is modulo 2^33; the true remainder always fits.
        div_ext   = {1'b0, m_q};
        div_shift = {hi_q[31:0], lo_q[31]};
        div_sum   = hi_q[32] ? (div_shift + div_ext) : (div_shift - div_ext);
        rem_fix   = hi_q[32] ? (hi_q[32:0] + div_ext) : hi_q[32:0];
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        qm1_d         = qm1_q;
        m_d           = m_q;
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        dbz_d         = dbz_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        result_hi_d   = result_hi_q;
        result_lo_d   = result_lo_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start && (opcode == MUL_OP || opcode == DIV_OP)) begin
                    busy_d        = 1'b1;
                    div_by_zero_d = 1'b0;
                    cnt_d         = 5'd0;
                    sign_a_d      = a[31];
                    sign_b_d      = b[31];
                    qm1_d         = 1'b0;
                    hi_d          = 34'd0;
                    dbz_d         = 1'b0;
                    if (opcode == MUL_OP) begin
                        m_d     = a;
                        lo_d    = b;
                        state_d = S_MUL;
                    end else if (b == 32'd0) begin
                        // Divide by zero bypasses the datapath entirely
                        m_d     = 32'd0;
                        hi_d    = {2'b00, a};
                        lo_d    = 32'hFFFF_FFFF;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        m_d     = b[31] ? -b : b;
                        lo_d    = a[31] ? -a : a;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                hi_d  = {{2{booth_sum[33]}}, booth_sum[33:2]};
                lo_d  = {booth_sum[1:0], lo_q[31:2]};
                qm1_d = lo_q[1];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) state_d = S_DONE;
            end
            S_DIV: begin
                hi_d  = {div_sum[32], div_sum};
                lo_d  = {lo_q[30:0], ~div_sum[32]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                // Quotient truncates toward zero; remainder follows the dividend.
                // 0x80000000 / -1 wraps back to 0x80000000 through the negation.
                hi_d    = {2'b00, sign_a_q ? -rem_fix[31:0] : rem_fix[31:0]};
                lo_d    = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                result_hi_d   = hi_q[31:0];
                result_lo_d   = lo_q;
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q       <= S_IDLE;
            cnt_q         <= 5'd0;
            hi_q          <= 34'd0;
            lo_q          <= 32'd0;
            qm1_q         <= 1'b0;
            m_q           <= 32'd0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_hi_q   <= 32'd0;
            result_lo_q   <= 32'd0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            qm1_q         <= qm1_d;
            m_q           <= m_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            dbz_q         <= dbz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_hi_q   <= result_hi_d;
            result_lo_q   <= result_lo_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_hi   = result_hi_q;
    assign result_lo   = result_lo_q;
    assign div_by_zero = div_by_zero_q;

endmodule
`default_nettype wire
